// File: rtl/sn76489_pkg.sv
// sn76489_pkg: shared command type, FSM states and byte-encoding constants for the SN76489 writer
package sn76489_pkg;

    typedef struct packed {
        logic [1:0] chan;
        logic       kind;
        logic [9:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

    localparam logic       LATCH_BIT  = 1'b1;
    localparam logic       ATT_BIT    = 1'b1;
    localparam logic [1:0] NOISE_CHAN = 2'd3;

endpackage

// File: rtl/sn76489_cmd_fifo.sv
// sn76489_cmd_fifo: count-based synchronous command FIFO; a push while full is refused even alongside a pop
module sn76489_cmd_fifo
    import sn76489_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_push,
    input  cmd_t in_data,
    input  logic in_pop,
    output cmd_t out_data,
    output logic out_full,
    output logic out_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [CW-1:0]  count;
    logic           push_ok, pop_ok;

    assign out_full  = count == CW'(DEPTH);
    assign out_empty = count == '0;
    assign push_ok   = in_push && !out_full;
    assign pop_ok    = in_pop && !out_empty;
    assign out_data  = mem[rp];

    // storage write; contents need no reset since the count gates every read
    always_ff @(posedge in_clk) begin
        if (push_ok) mem[wp] <= in_data;
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sn76489_writer.sv
// sn76489_writer: buffers channel commands and serialises them into strobed SN76489 write bytes
// Build option: SN76489_WRITER_SKIP_HI_EN skips the tone data byte when its high bits are unchanged
module sn76489_writer
    import sn76489_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_HOLD    = 2,
    parameter int WR_GAP     = 2
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_cmd_valid,
    output logic       out_cmd_ready,
    input  logic [1:0] in_cmd_chan,
    input  logic       in_cmd_kind,
    input  logic [9:0] in_cmd_data,
    output logic [7:0] out_val,
    output logic       out_wr,
    output logic       out_busy
);
    state_t     state, state_d;
    cmd_t       head;
    logic       full, empty, push, pop;
    logic [7:0] cnt, cnt_d;
    logic [7:0] val_d, first;
    logic       pend, pend_d;
    logic [5:0] hi, hi_d;
    logic       is_noise, two_byte, skip;

    assign out_cmd_ready = !full;
    assign push          = in_cmd_valid && out_cmd_ready;
    assign out_wr        = state == WR;

    sn76489_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_push  (push),
        .in_data  ({in_cmd_chan, in_cmd_kind, in_cmd_data}),
        .in_pop   (pop),
        .out_data (head),
        .out_full (full),
        .out_empty(empty)
    );

`ifdef SN76489_WRITER_SKIP_HI_EN
    logic [5:0] shadow [4];
    logic [3:0] shadow_ok;
    logic [1:0] hi_chan;

    assign skip = shadow_ok[head.chan] && shadow[head.chan] == head.data[9:4];

    // shadow contents track the last data byte sent per channel
    always_ff @(posedge in_clk) begin
        if (state == GAP && state_d == WR) shadow[hi_chan] <= hi;
    end

    // shadow valid bits and the channel of the pending data byte
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            shadow_ok <= '0;
            hi_chan   <= '0;
        end else begin
            if (pop) hi_chan <= head.chan;
            if (state == GAP && state_d == WR) shadow_ok[hi_chan] <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    assign is_noise = head.chan == NOISE_CHAN;
    assign two_byte = !head.kind && !is_noise && !skip;
    assign first    = head.kind ? {LATCH_BIT, head.chan, ATT_BIT, head.data[3:0]}
                    : is_noise  ? {LATCH_BIT, NOISE_CHAN, 2'b00, head.data[2:0]}
                    :             {LATCH_BIT, head.chan, 1'b0, head.data[3:0]};

    // next-state: pop and load in IDLE, time the strobe in WR, space bytes in GAP
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        val_d   = out_val;
        pend_d  = pend;
        hi_d    = hi;
        pop     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                val_d   = first;
                pend_d  = two_byte;
                hi_d    = head.data[9:4];
                cnt_d   = '0;
                state_d = WR;
            end
            WR: begin
                cnt_d   = cnt == 8'(WR_HOLD - 1) ? '0 : cnt + 8'd1;
                state_d = cnt == 8'(WR_HOLD - 1) ? GAP : WR;
            end
            GAP: if (cnt == 8'(WR_GAP - 1)) begin
                cnt_d   = '0;
                val_d   = pend ? {2'b00, hi} : out_val;
                pend_d  = 1'b0;
                state_d = pend ? WR : IDLE;
            end else begin
                cnt_d = cnt + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, byte and busy registers; busy stays high while work remains after this edge
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            out_val  <= 8'h00;
            pend     <= 1'b0;
            hi       <= '0;
            out_busy <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            out_val  <= val_d;
            pend     <= pend_d;
            hi       <= hi_d;
            out_busy <= state_d != IDLE || push || !empty;
        end
    end

endmodule

// File: doc/sn76489_writer.md
# sn76489_writer

Command-side driver for the SN76489 PSG core. Accepts channel-level register commands (tone period, noise control, attenuation) through a valid/ready handshake, buffers them in a small FIFO, and serialises each into the one- or two-byte SN76489 write sequence. Each byte is presented with a strobe pulse on the PSG's byte/write inputs. It sits between the VGM command stream and the PSG core, so upstream logic never deals with latch/data byte encoding or strobe spacing.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `WR_HOLD`, 2: cycles `out_wr` is held high per byte; ≥1.
- `WR_GAP`, 2: cycles `out_wr` is held low after each byte before the next may start; ≥1.
- `in_clk`  in  1  clock.
- `in_rst_n`  in  1  reset; asynchronous, active-low.
- `in_cmd_valid`  in  1  command present.
- `out_cmd_ready`  out  1  FIFO can accept; a command transfers on a rising edge with valid & ready.
- `in_cmd_chan`  in  2  channel 0–2 tone, 3 noise.
- `in_cmd_kind`  in  1  0 = tone period / noise control, 1 = attenuation.
- `in_cmd_data`  in  10  period (10 b), attenuation [3:0], or noise control [2:0] (fb = [2], period = [1:0]).
- `out_val`  out  8  byte to PSG.
- `out_wr`  out  1  write strobe to PSG; PSG samples on its rising edge.
- `out_busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Encoding:
  - attenuation → one byte {1, chan, 1, data[3:0]};
  - noise control (chan 3, kind 0) → one byte {1, 11, 0, 0, data[2:0]};
  - tone (chan 0–2, kind 0) → latch byte {1, chan, 0, data[3:0]}, then data byte {0, 0, data[9:4]}.
- Unused data bits are ignored.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load `out_val` with the first byte, go to WR.
  - WR: `out_wr`=1 for WR_HOLD cycles, then go to GAP.
  - GAP: `out_wr`=0 for WR_GAP cycles. If a second byte is pending, load it into `out_val` and go to WR; otherwise go to IDLE.
- `out_val` changes only when entering WR and holds until the next load.
- Bytes are emitted strictly in command order; no command is dropped or merged.
- FIFO:
  - `out_cmd_ready` = !full, computed from the current count.
  - A push while full is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop when non-full leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values (asynchronous): `out_val`=0x00, `out_wr`=0, `out_cmd_ready`=1, `out_busy`=0. FIFO is emptied and FSM returns to IDLE.
- Reset mid-pulse drops `out_wr` immediately. The partially issued sequence is discarded.
- Latency with FIFO empty and FSM in IDLE: command accepted at edge E; pop at E+1; `out_wr` high from edge E+1 to edge E+1+WR_HOLD.
- Byte pitch is WR_HOLD+WR_GAP cycles. A two-byte tone command occupies 2·(WR_HOLD+WR_GAP) cycles.
- When the FSM leaves GAP for IDLE, the next pop happens in the IDLE cycle. Back-to-back commands therefore have a pitch of WR_HOLD+WR_GAP+1 cycles.
- `out_busy` is registered and falls on the edge where the FSM enters IDLE with the FIFO empty.

## Configuration
- `SN76489_WRITER_SKIP_HI_EN` defined:
  - A per-channel shadow register (with a valid bit) holds the last emitted data[9:4].
  - A tone command whose data[9:4] matches a valid shadow emits only the latch byte.
  - Shadows are invalidated on reset and updated whenever a data byte is emitted.
- Not defined: every tone command emits both bytes. No shadow logic is present.

## Structure
- Shared package `sn76489_pkg`:
  - command struct (chan, kind, data);
  - FSM state enum;
  - byte-encoding constants (latch bit, attenuation type bit, noise channel id 2'd3).
- One sub-module, `sn76489_cmd_fifo`: synchronous FIFO with count-based full/empty and async active-low reset. The FSM, encoder and shadows live in the top level.

## Test plan
- Tone ch1, data 0x2A5, defaults → `out_val` 0xA5 with `out_wr` high 2 cycles, low 2 cycles, then 0x2A high 2 cycles; `out_busy` low after.
- Attenuation ch2, data 0x00F → single byte 0xDF. Noise ch3, data 0x005 → single byte 0xE5.
- Six attenuation ch0 commands, data 0–5, with valid held every cycle → `out_cmd_ready` deasserts while the FIFO is full. Bytes 0x90..0x95 appear in order; all six are accepted; pitch is 5 cycles between back-to-back commands.
- Tone ch0, data 0x155 then 0x15A:
  - with SKIP_HI_EN → 0x85, 0x15, 0x8A;
  - without → 0x85, 0x15, 0x8A, 0x15.
- Assert `in_rst_n`=0 during the first WR cycle of a tone command → `out_wr`=0 and `out_val`=0x00 immediately. After release, no data byte appears; `out_cmd_ready`=1.
- FIFO full with push and pop in the same cycle → the push is refused and the count decrements by 1.
